// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the Ram-port arbiter: FSM states, latched request record, size limit.
package mem_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } ArbState;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } MemReq;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake plus Ram-side bus of the shared memory port.
// The master modport is the requester/Ram side, the slave modport is the arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 3
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0][31:0]  req_addr;
  logic [NUM_REQ-1:0][31:0]  req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [31:0]               rdata;
  logic [OW-1:0]             owner;
  logic                      busy;
  logic [31:0]               mem_addr_bus;
  logic                      write_enable;
  logic [31:0]               bus_to_mem_32;
  logic [31:0]               bus_from_mem_32;

  modport master (
    output req, req_we, req_addr, req_wdata, bus_from_mem_32,
    input  ack, err, rdata, owner, busy, mem_addr_bus, write_enable, bus_to_mem_32
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, bus_from_mem_32,
    output ack, err, rdata, owner, busy, mem_addr_bus, write_enable, bus_to_mem_32
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner search: first set request at or above start, wrapping at NUM_REQ.
module arb_pick #(
  parameter  int NUM_REQ = 3,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] rot;
  logic [IW-1:0]        off;
  logic [IW:0]          sum;

  // Rotate so bit k of rot is requester (start+k) mod NUM_REQ.
  assign dbl = {req, req};
  assign rot = dbl >> start;

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = IW'(k);
      end
    end
  end

  always_comb begin
    sum    = {1'b0, start} + {1'b0, off};
    winner = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit Ram port between NUM_REQ requesters, one 3-cycle access at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          NUM_REQ   = 3,
  parameter logic [31:0] MEM_BYTES = 32'hffff
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int OW = $clog2(NUM_REQ);

  ArbState              state_q, state_d;
  MemReq                cur_q, req_sel;
  logic [OW-1:0]        owner_q, start, winner;
  logic                 pick_vld, range_err;
  logic [32:0]          end_addr;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic [NUM_REQ-1:0]   ack;
  logic [31:0]          mem_addr, mem_wdata;
  logic                 mem_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [OW-1:0] rr_ptr_q;

  // Pointer moves past the owner as the access completes, so the next IDLE starts after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   rr_ptr_q <= '0;
    else if (state_q == ACCESS) rr_ptr_q <= (owner_q == OW'(NUM_REQ-1)) ? '0 : owner_q + OW'(1);
  end
  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .start  (start),
    .valid  (pick_vld),
    .winner (winner)
  );

  assign req_sel = '{we: bus.req_we[winner], addr: bus.req_addr[winner], wdata: bus.req_wdata[winner]};

  // Writes must fit all four bytes; 33-bit sum keeps addresses near 2^32 from wrapping.
  assign end_addr  = {1'b0, cur_q.addr} + (cur_q.we ? 33'd3 : 33'd0);
  assign range_err = end_addr >= {1'b0, MEM_BYTES};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= '0;
      cur_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && pick_vld) begin
        owner_q <= winner;
        cur_q   <= req_sel;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (cur_q.we || range_err) ? 32'h0 : bus.bus_from_mem_32;
        err_q   <= range_err;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    ack       = '0;
    case (state_q)
      ACCESS: begin
        mem_addr  = cur_q.addr;
        mem_wdata = cur_q.wdata;
        mem_we    = cur_q.we && !range_err;
      end
      ACK:     ack[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus.ack           = ack;
  assign bus.err           = err_q;
  assign bus.rdata         = rdata_q;
  assign bus.owner         = owner_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_addr_bus  = mem_addr;
  assign bus.write_enable  = mem_we;
  assign bus.bus_to_mem_32 = mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected acks queued at issue, checked by a monitor.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(N)) bus ();

  mem_port_arbiter #(.NUM_REQ(N), .MEM_BYTES(32'hffff)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [0:65535];
  assign bus.bus_from_mem_32 = ram[bus.mem_addr_bus[15:0]];
  always @(posedge clk) if (bus.write_enable) ram[bus.mem_addr_bus[15:0]] <= bus.bus_to_mem_32;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   we_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack pulse consumes the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ack !== '0) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack=%b, none expected", bus.ack);
        end else begin
          e = sbq.pop_front();
          chk("ack_onehot", 32'(bus.ack), 32'(1 << e.idx));
          chk("err", 32'(bus.err), 32'(e.err));
          chk("rdata", bus.rdata, e.rdata);
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic e_err, input logic [31:0] e_rd);
    exp_t e;
    e.idx = i; e.err = e_err; e.rdata = e_rd;
    sbq.push_back(e);
  endtask

  // One transaction from IDLE; returns cycles until ack, leaves one idle cycle after.
  task automatic issue(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e_err, input logic [31:0] e_rd, output int lat);
    bit got;
    push_exp(i, e_err, e_rd);
    bus.req_we[i]    = we;
    bus.req_addr[i]  = addr;
    bus.req_wdata[i] = wdata;
    bus.req[i]       = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.write_enable) we_seen = 1'b1;
      if (bus.ack[i]) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_timeout: requester %0d got no ack, want ack within 20 cycles", i);
    end
    bus.req[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int nack;
    for (int a = 0; a < 65536; a++) ram[a] = 32'h0;
    ram[32'h80]   = 32'h58;
    ram[32'h84]   = 32'h0000_084a;
    ram[32'h88]   = 32'h0000_088b;
    ram[0]        = 32'h1111_1111;
    ram[32'hfffc] = 32'h0000_0077;
    ram[32'hfffe] = 32'h0000_5a5a;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;

    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_we", 32'(bus.write_enable), 32'h0);
    chk("rst_addr", bus.mem_addr_bus, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a write access.
    bus.req_we[1] = 1'b1; bus.req_addr[1] = 32'h10; bus.req_wdata[1] = 32'habcd; bus.req[1] = 1'b1;
    @(posedge clk); #1;
    chk("access_we", 32'(bus.write_enable), 32'h1);
    chk("access_addr", bus.mem_addr_bus, 32'h10);
    rst = 1'b1;
    #1;
    chk("async_we_drop", 32'(bus.write_enable), 32'h0);
    bus.req[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    chk("post_rst_ack", 32'(bus.ack), 32'h0);
    chk("post_rst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;

    issue(1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h58, lat);
    chk("read_latency", 32'(lat), 32'd2);

    issue(2, 1'b1, 32'hff, 32'h0000_0293, 1'b0, 32'h0, lat);
    chk("ram_ff", ram[32'hff], 32'h0000_0293);
    issue(0, 1'b0, 32'hff, 32'h0, 1'b0, 32'h0000_0293, lat);

    we_seen = 1'b0;
    issue(1, 1'b1, 32'h1_0000, 32'hdead, 1'b1, 32'h0, lat);
    issue(0, 1'b1, 32'hfffc, 32'h1234, 1'b1, 32'h0, lat);
    issue(0, 1'b0, 32'hffff, 32'h0, 1'b1, 32'h0, lat);
    chk("oor_we_seen", 32'(we_seen), 32'h0);
    chk("oor_ram0", ram[0], 32'h1111_1111);
    chk("oor_ramfffc", ram[32'hfffc], 32'h0000_0077);
    issue(2, 1'b0, 32'hfffe, 32'h0, 1'b0, 32'h0000_5a5a, lat);
    issue(1, 1'b1, 32'hfffb, 32'hcafe, 1'b0, 32'h0, lat);
    chk("edge_write", ram[32'hfffb], 32'h0000_cafe);

    // Contention: all three hold reads from a fresh pointer.
    do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_exp(0, 1'b0, 32'h58);
    push_exp(1, 1'b0, 32'h084a);
    push_exp(2, 1'b0, 32'h088b);
    push_exp(0, 1'b0, 32'h58);
`else
    for (int k = 0; k < 4; k++) push_exp(0, 1'b0, 32'h58);
`endif
    bus.req_we = '0;
    bus.req_addr[0] = 32'h80; bus.req_addr[1] = 32'h84; bus.req_addr[2] = 32'h88;
    bus.req = 3'b111;
    nack = 0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      @(posedge clk); #1;
      if (bus.ack !== '0) nack++;
    end
    bus.req = '0;
    chk("contention_acks", 32'(nack), 32'd4);
    @(posedge clk); #1;

    // Requester 0 drops during ACCESS; requester 1 becomes pending.
    push_exp(0, 1'b0, 32'h58);
    push_exp(1, 1'b0, 32'h084a);
    bus.req_addr[0] = 32'h80; bus.req[0] = 1'b1;
    @(posedge clk); #1;
    bus.req[0] = 1'b0;
    bus.req_addr[1] = 32'h84; bus.req[1] = 1'b1;
    nack = 0;
    for (int c = 0; c < 20 && nack == 0; c++) begin
      @(posedge clk); #1;
      if (bus.ack[1]) nack = 1;
    end
    bus.req[1] = 1'b0;
    chk("dropped_then_pending", 32'(nack), 32'd1);

    for (int c = 0; c < 10 && sbq.size() != 0; c++) @(posedge clk);
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
